// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds two WIDTH-bit operands DIGIT bits per clock
// through a registered carry, with valid/ready handshakes on both sides.
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf,
   output logic             busy
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] a_q, b_q, s_q;
   logic             carry_q, c_out_q, ovf_q;
   logic [CNT_W-1:0] cnt_q;

   logic [DIGIT:0]   digit_sum;
   logic [WIDTH-1:0] digit_ext;
   logic             msb_carry_in;
   logic             last_digit;
   logic             accept;

   // One DIGIT-wide slice; the extra bit is the digit carry-out.
   always_comb begin
      digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_q};
      digit_ext = '0;
      digit_ext[DIGIT-1:0] = digit_sum[DIGIT-1:0];
   end

   // Carry into the top bit of the digit, recovered from that bit's sum:
   // for the last digit this is the carry into the operand MSB.
   assign msb_carry_in = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ digit_sum[DIGIT-1];
   assign last_digit   = (cnt_q == CNT_W'(N - 1));
   assign accept       = (state_q == IDLE) && in_valid;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid)   state_d = RUN;
         RUN:  if (last_digit) state_d = DONE;
         DONE: if (out_ready)  state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: the operand shift registers are reset too; they are plain flops,
   // not a memory array, and resetting them keeps s deterministic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (accept) begin
            // Subtraction as x + ~y + ~c_in: invert B and the incoming borrow.
            a_q     <= x;
            b_q     <= sub ? ~y : y;
            carry_q <= c_in ^ sub;
            cnt_q   <= '0;
         end else if (state_q == RUN) begin
            s_q     <= (s_q >> DIGIT) | (digit_ext << (WIDTH - DIGIT));
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            carry_q <= digit_sum[DIGIT];
            if (last_digit) begin
               c_out_q <= digit_sum[DIGIT];
               ovf_q   <= msb_carry_in ^ digit_sum[DIGIT];
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign s         = s_q;
   assign c_out     = c_out_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench: directed cases on DIGIT=4 plus random sweeps on
// DIGIT = 1, 4 and 16 against an integer-arithmetic reference.
module tb_digit_serial_adder;

   localparam int WIDTH = 16;
   localparam int NRAND = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             in_valid  [3];
   logic             in_ready  [3];
   logic [WIDTH-1:0] x         [3];
   logic [WIDTH-1:0] y         [3];
   logic             c_in      [3];
   logic             sub       [3];
   logic             out_valid [3];
   logic             out_ready [3];
   logic [WIDTH-1:0] s         [3];
   logic             c_out     [3];
   logic             ovf       [3];
   logic             busy      [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      digit_serial_adder #(
         .WIDTH(WIDTH),
         .DIGIT((g == 0) ? 1 : (g == 1) ? 4 : 16)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid[g]),
         .in_ready (in_ready[g]),
         .x        (x[g]),
         .y        (y[g]),
         .c_in     (c_in[g]),
         .sub      (sub[g]),
         .out_valid(out_valid[g]),
         .out_ready(out_ready[g]),
         .s        (s[g]),
         .c_out    (c_out[g]),
         .ovf      (ovf[g]),
         .busy     (busy[g])
      );
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(input int k);
      return (k == 0) ? 16 : (k == 1) ? 4 : 1;
   endfunction

   // Reference: {ovf, c_out, s} from plain signed/unsigned integer arithmetic.
   function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic ci, input logic sb);
      int ua, ub, ur, sa, sbv, sr;
      logic [15:0] rs;
      logic rc, ro;
      ua  = int'(a);
      ub  = int'(b);
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      ur  = sb ? ua - ub - int'(ci) : ua + ub + int'(ci);
      sr  = sb ? sa - sbv - int'(ci) : sa + sbv + int'(ci);
      rs  = ur[15:0];
      rc  = sb ? (ur >= 0) : (ur > 65535);
      ro  = (sr > 32767) || (sr < -32768);
      return {ro, rc, rs};
   endfunction

   // One transaction on instance k; drives at +1 after an edge, samples there too.
   task automatic run_txn(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb, input string tag);
      logic [17:0] exp;
      int lat;
      exp = ref_model(a, b, ci, sb);
      check({tag, ".in_ready"}, 32'(in_ready[k]), 32'd1);
      x[k] = a; y[k] = b; c_in[k] = ci; sub[k] = sb; in_valid[k] = 1'b1;
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      x[k] = ~a; y[k] = ~b; c_in[k] = ~ci; sub[k] = ~sb;
      lat = 0;
      while (out_valid[k] !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(lat_of(k)));
      check({tag, ".s"},       32'(s[k]),     32'(exp[15:0]));
      check({tag, ".c_out"},   32'(c_out[k]), 32'(exp[16]));
      check({tag, ".ovf"},     32'(ovf[k]),   32'(exp[17]));
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
      check({tag, ".release"}, 32'({in_ready[k], out_valid[k]}), 32'b10);
   endtask

   initial begin
      logic [15:0] held_s;
      logic held_c, held_o;
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b0;
         x[k] = '0; y[k] = '0; c_in[k] = 1'b0; sub[k] = 1'b0;
      end
      #2;
      for (int k = 0; k < 3; k++)
         check($sformatf("reset%0d", k),
               32'({in_ready[k], out_valid[k], busy[k], c_out[k], ovf[k], s[k]}),
               32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed cases, DIGIT=4
      run_txn(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, "add_basic");
      run_txn(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
      run_txn(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
      run_txn(1, 16'h0005, 16'h0007, 1'b0, 1'b1, "sub_neg");
      run_txn(1, 16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
      run_txn(1, 16'h0010, 16'h0001, 1'b1, 1'b1, "sub_borrow");
      check("sub_borrow.s_const", 32'(s[1]), 32'h000E);

      // Backpressure: result held while inputs toggle
      x[1] = 16'h1234; y[1] = 16'h0FFF; c_in[1] = 1'b0; sub[1] = 1'b0; in_valid[1] = 1'b1;
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check("bp.valid", 32'(out_valid[1]), 32'd1);
      held_s = s[1]; held_c = c_out[1]; held_o = ovf[1];
      check("bp.s_initial", 32'(held_s), 32'h2233);
      for (int i = 0; i < 5; i++) begin
         x[1] = 16'($urandom); y[1] = 16'($urandom); in_valid[1] = i[0];
         @(posedge clk); #1;
         check("bp.hold", 32'({out_valid[1], in_ready[1], s[1], c_out[1], ovf[1]}),
               32'({1'b1, 1'b0, held_s, held_c, held_o}));
      end
      in_valid[1] = 1'b0; out_ready[1] = 1'b1;
      @(posedge clk); #1;
      out_ready[1] = 1'b0;
      check("bp.release", 32'({in_ready[1], out_valid[1], busy[1]}), 32'b100);

      // Reset on the 2nd RUN cycle aborts the operation
      x[1] = 16'h1234; y[1] = 16'h1111; c_in[1] = 1'b0; sub[1] = 1'b0; in_valid[1] = 1'b1;
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      @(posedge clk); #1;
      check("abort.busy", 32'(busy[1]), 32'd1);
      rst = 1'b1;
      #1;
      check("abort.state", 32'({out_valid[1], in_ready[1], busy[1], s[1]}),
            32'({1'b0, 1'b1, 1'b0, 16'h0000}));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort.no_result", 32'(out_valid[1]), 32'd0);
      run_txn(1, 16'h0001, 16'h0001, 1'b0, 1'b0, "after_abort");

      // Random sweep on all three digit widths
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < NRAND; i++)
            run_txn(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                    $sformatf("rnd_d%0d", (k == 0) ? 1 : (k == 1) ? 4 : 16));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
